// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bundle layout and instruction field slices for the MIPS pipeline
package pipe_pkg;
   localparam int CTRL_W      = 8;
   localparam int CTRL_WREG   = 0;
   localparam int CTRL_M2REG  = 1;
   localparam int CTRL_WMEM   = 2;
   localparam int CTRL_REGRT  = 3;
   localparam int CTRL_JAL    = 4;
   localparam int CTRL_ALUIMM = 5;
   localparam int CTRL_SHIFT  = 6;
   localparam int CTRL_SEXT   = 7;
   localparam int RS_HI = 25, RS_LO = 21;
   localparam int RT_HI = 20, RT_LO = 16;
   localparam int RD_HI = 15, RD_LO = 11;
   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the freshest value of one source register from EX, MEM, WB or the register file
module fwd_mux (
   input  logic [4:0]  rn,
   input  logic [31:0] q,
   input  logic        exs_valid,
   input  logic        exs_wreg,
   input  logic        exs_m2reg,
   input  logic [4:0]  exs_wn,
   input  logic [31:0] exs_alu,
   input  logic        mem_valid,
   input  logic        mem_wreg,
   input  logic        mem_m2reg,
   input  logic [4:0]  mem_wn,
   input  logic [31:0] mem_alu,
   input  logic [31:0] mem_mdata,
   input  logic        wb_we,
   input  logic [4:0]  wb_wn,
   input  logic [31:0] wb_d,
   output logic [31:0] d
);
   logic ex_hit, mem_hit, wb_hit;
   // A load still in EX has no data yet; the stall logic covers that case instead
   assign ex_hit  = exs_valid & exs_wreg & ~exs_m2reg & (exs_wn == rn);
   assign mem_hit = mem_valid & mem_wreg & (mem_wn == rn);
   // The register file writes at the edge, so its read port still shows the old value this cycle
   assign wb_hit  = wb_we & (wb_wn == rn);
   assign d = (rn == 5'd0) ? 32'd0 :
              ex_hit       ? exs_alu :
              mem_hit      ? (mem_m2reg ? mem_mdata : mem_alu) :
              wb_hit       ? wb_d : q;
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: reads and forwards operands, detects load-use hazards and registers ID/EX
module id_operand_stage
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              id_valid,
   input  logic [31:0]       id_inst,
   input  logic [31:0]       id_pc4,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              flush,
   output logic [4:0]        rna,
   output logic [4:0]        rnb,
   input  logic [31:0]       qa,
   input  logic [31:0]       qb,
   input  logic              exs_valid,
   input  logic              exs_wreg,
   input  logic              exs_m2reg,
   input  logic [4:0]        exs_wn,
   input  logic [31:0]       exs_alu,
   input  logic              mem_valid,
   input  logic              mem_wreg,
   input  logic              mem_m2reg,
   input  logic [4:0]        mem_wn,
   input  logic [31:0]       mem_alu,
   input  logic [31:0]       mem_mdata,
   input  logic              wb_we,
   input  logic [4:0]        wb_wn,
   input  logic [31:0]       wb_d,
   output logic              stall,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       ex_a,
   output logic [31:0]       ex_b,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_wn,
   output logic [31:0]       ex_pc4,
   output logic [CNT_W-1:0]  stall_cnt
);
   logic [31:0]       fa, fb;
   logic [4:0]        rd, wn_sel;
   logic [CTRL_W-1:0] ctrl_v;
   logic              bubble, unused;
   assign rna    = id_inst[RS_HI:RS_LO];
   assign rnb    = id_inst[RT_HI:RT_LO];
   assign rd     = id_inst[RD_HI:RD_LO];
   assign unused = ^id_inst[31:26];
   fwd_mux u_fwd_a (
      .rn(rna), .q(qa),
      .exs_valid(exs_valid), .exs_wreg(exs_wreg), .exs_m2reg(exs_m2reg), .exs_wn(exs_wn), .exs_alu(exs_alu),
      .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wn(mem_wn),
      .mem_alu(mem_alu), .mem_mdata(mem_mdata),
      .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d), .d(fa)
   );
   fwd_mux u_fwd_b (
      .rn(rnb), .q(qb),
      .exs_valid(exs_valid), .exs_wreg(exs_wreg), .exs_m2reg(exs_m2reg), .exs_wn(exs_wn), .exs_alu(exs_alu),
      .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wn(mem_wn),
      .mem_alu(mem_alu), .mem_mdata(mem_mdata),
      .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d), .d(fb)
   );
   assign stall = id_valid & exs_valid & exs_wreg & exs_m2reg & (exs_wn != 5'd0) &
                  ((id_use_rs & (exs_wn == rna)) | (id_use_rt & (exs_wn == rnb)));
   assign bubble = flush | stall;
   assign ctrl_v = id_valid ? id_ctrl : '0;
   assign wn_sel = ~ctrl_v[CTRL_WREG] ? 5'd0 :
                   ctrl_v[CTRL_JAL]   ? 5'd31 :
                   ctrl_v[CTRL_REGRT] ? rnb : rd;
   // ID/EX latch: a bubble (all zero) on flush or load-use stall, otherwise capture the ID instruction
   always_ff @(posedge clk or posedge clrn)
      if (clrn) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_imm   <= '0;
         ex_wn    <= '0;
         ex_pc4   <= '0;
      end else begin
         ex_valid <= ~bubble & id_valid;
         ex_ctrl  <= bubble ? '0 : ctrl_v;
         ex_a     <= bubble ? '0 : fa;
         ex_b     <= bubble ? '0 : fb;
         ex_imm   <= bubble ? '0 : sext16(id_inst[15:0]);
         ex_wn    <= bubble ? '0 : wn_sel;
         ex_pc4   <= bubble ? '0 : id_pc4;
      end
   // Count load-use stall cycles that were not squashed by a flush, holding at all-ones
   always_ff @(posedge clk or posedge clrn)
      if (clrn)
         stall_cnt <= '0;
      else if (stall & ~flush & ~&stall_cnt)
         stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed table, hand sequences and a randomized model check of id_operand_stage
module tb_id_operand_stage;
   import pipe_pkg::*;
   logic clk = 1'b0, clrn = 1'b1;
   logic id_valid, flush, id_use_rs, id_use_rt;
   logic [31:0] id_inst, id_pc4, qa, qb, exs_alu, mem_alu, mem_mdata, wb_d;
   logic [CTRL_W-1:0] id_ctrl, ex_ctrl;
   logic exs_valid, exs_wreg, exs_m2reg, mem_valid, mem_wreg, mem_m2reg, wb_we;
   logic [4:0] exs_wn, mem_wn, wb_wn, rna, rnb, ex_wn;
   logic stall, ex_valid;
   logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
   logic [15:0] stall_cnt;
   int checks = 0, errors = 0;
   logic [15:0] m_cnt = 16'd0;

   id_operand_stage dut (
      .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_inst(id_inst), .id_pc4(id_pc4),
      .id_ctrl(id_ctrl), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .flush(flush),
      .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
      .exs_valid(exs_valid), .exs_wreg(exs_wreg), .exs_m2reg(exs_m2reg), .exs_wn(exs_wn), .exs_alu(exs_alu),
      .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wn(mem_wn),
      .mem_alu(mem_alu), .mem_mdata(mem_mdata), .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
      .stall(stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
      .ex_imm(ex_imm), .ex_wn(ex_wn), .ex_pc4(ex_pc4), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_in();
      id_valid = 0; id_inst = 0; id_pc4 = 0; id_ctrl = 0; id_use_rs = 1; id_use_rt = 1; flush = 0;
      qa = 0; qb = 0; exs_valid = 0; exs_wreg = 0; exs_m2reg = 0; exs_wn = 0; exs_alu = 0;
      mem_valid = 0; mem_wreg = 0; mem_m2reg = 0; mem_wn = 0; mem_alu = 0; mem_mdata = 0;
      wb_we = 0; wb_wn = 0; wb_d = 0;
   endtask

   // Reference: newest producer in program order wins; r0 is hardwired zero; loads in EX have no value yet
   function automatic logic [31:0] m_opnd(input logic [4:0] r, input logic [31:0] q);
      logic        hit[3];
      logic [4:0]  dst[3];
      logic [31:0] val[3];
      hit = '{exs_valid & exs_wreg & ~exs_m2reg, mem_valid & mem_wreg, wb_we};
      dst = '{exs_wn, mem_wn, wb_wn};
      val = '{exs_alu, mem_m2reg ? mem_mdata : mem_alu, wb_d};
      if (r == 5'd0) return 32'd0;
      foreach (hit[i]) if (hit[i] && dst[i] == r) return val[i];
      return q;
   endfunction

   function automatic logic m_stall();
      logic [4:0] rs, rt;
      logic       load_in_ex;
      rs = id_inst[25:21];
      rt = id_inst[20:16];
      load_in_ex = exs_valid && exs_wreg && exs_m2reg && exs_wn != 5'd0;
      return id_valid && load_in_ex && ((id_use_rs && exs_wn == rs) || (id_use_rt && exs_wn == rt));
   endfunction

   function automatic logic [4:0] m_dest();
      if (!id_valid || !id_ctrl[CTRL_WREG]) return 5'd0;
      if (id_ctrl[CTRL_JAL]) return 5'd31;
      return id_ctrl[CTRL_REGRT] ? id_inst[20:16] : id_inst[15:11];
   endfunction

   task automatic model_step();
      logic        s, bub;
      logic        x_valid;
      logic [7:0]  x_ctrl;
      logic [31:0] x_a, x_b, x_imm, x_pc4;
      logic [4:0]  x_wn;
      s = m_stall();
      bub = s || flush;
      x_valid = !bub && id_valid;
      x_ctrl  = x_valid ? id_ctrl : 8'd0;
      x_a     = bub ? 32'd0 : m_opnd(id_inst[25:21], qa);
      x_b     = bub ? 32'd0 : m_opnd(id_inst[20:16], qb);
      x_imm   = bub ? 32'd0 : 32'($signed(id_inst[15:0]));
      x_wn    = bub ? 5'd0 : m_dest();
      x_pc4   = bub ? 32'd0 : id_pc4;
      if (s && !flush && m_cnt != 16'hFFFF) m_cnt++;
      #1;
      chk("rnd_stall", 32'(stall), 32'(s));
      @(posedge clk);
      #1;
      chk("rnd_valid", 32'(ex_valid), 32'(x_valid));
      chk("rnd_ctrl", 32'(ex_ctrl), 32'(x_ctrl));
      chk("rnd_a", ex_a, x_a);
      chk("rnd_b", ex_b, x_b);
      chk("rnd_imm", ex_imm, x_imm);
      chk("rnd_wn", 32'(ex_wn), 32'(x_wn));
      chk("rnd_pc4", ex_pc4, x_pc4);
      chk("rnd_cnt", 32'(stall_cnt), 32'(m_cnt));
   endtask

   task automatic set_load_use();
      clear_in();
      id_valid = 1; id_inst = {6'd0, 5'd4, 5'd1, 5'd5, 5'd0, 6'h20}; id_ctrl = 8'h01; qb = 32'd3;
      exs_valid = 1; exs_wreg = 1; exs_m2reg = 1; exs_wn = 5'd4;
   endtask

   typedef struct {
      logic id_valid; logic [31:0] inst; logic [7:0] ctrl; logic [31:0] qa, qb;
      logic ev, ew, em; logic [4:0] ewn; logic [31:0] ealu;
      logic mv, mw, mm; logic [4:0] mwn; logic [31:0] malu, mdat;
      logic wwe; logic [4:0] wwn; logic [31:0] wd;
      logic x_stall, x_valid; logic [31:0] x_a, x_b, x_imm; logic [4:0] x_wn;
   } vec_t;
   vec_t tbl[9];

   initial begin
      logic [4:0] exp_rn;
      tbl[0] = '{id_valid:1, inst:32'h00221820, ctrl:8'h01, qa:5, qb:7,
                 x_valid:1, x_a:5, x_b:7, x_imm:32'h1820, x_wn:3, default:0};
      tbl[1] = '{id_valid:1, inst:32'h00221820, ctrl:8'h01, qa:5, qb:7, ev:1, ew:1, ewn:1, ealu:32'h10,
                 mv:1, mw:1, mwn:1, malu:32'h20, x_valid:1, x_a:32'h10, x_b:7, x_imm:32'h1820, x_wn:3, default:0};
      tbl[2] = '{id_valid:1, inst:32'h00221820, ctrl:8'h01, qa:5, qb:0, wwe:1, wwn:2, wd:32'hABCD,
                 x_valid:1, x_a:5, x_b:32'hABCD, x_imm:32'h1820, x_wn:3, default:0};
      tbl[3] = '{id_valid:1, inst:32'h00221820, ctrl:8'h01, qa:5, qb:0, wwe:1, wwn:0, wd:32'hABCD,
                 x_valid:1, x_a:5, x_b:0, x_imm:32'h1820, x_wn:3, default:0};
      tbl[4] = '{id_valid:1, inst:32'h2026FFFC, ctrl:8'h29, qa:9, qb:32'h77,
                 x_valid:1, x_a:9, x_b:32'h77, x_imm:32'hFFFFFFFC, x_wn:6, default:0};
      tbl[5] = '{id_valid:1, inst:32'h00023820, ctrl:8'h01, qa:32'h99, qb:1, ev:1, ew:1, ewn:0, ealu:32'h44,
                 mv:1, mw:1, mm:1, mwn:2, malu:32'h11, mdat:32'h22,
                 x_valid:1, x_a:0, x_b:32'h22, x_imm:32'h3820, x_wn:7, default:0};
      tbl[6] = '{id_valid:1, inst:32'h0C000010, ctrl:8'h11, qa:3, qb:4,
                 x_valid:1, x_a:0, x_b:0, x_imm:32'h10, x_wn:31, default:0};
      tbl[7] = '{id_valid:0, inst:32'h00221820, ctrl:8'h01, qa:5, qb:7,
                 x_valid:0, x_a:5, x_b:7, x_imm:32'h1820, x_wn:0, default:0};
      tbl[8] = '{id_valid:1, inst:32'h00221820, ctrl:8'h0C, qa:5, qb:7,
                 x_valid:1, x_a:5, x_b:7, x_imm:32'h1820, x_wn:0, default:0};

      clear_in();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(ex_valid), 0);
      chk("rst_ctrl", 32'(ex_ctrl), 0);
      chk("rst_a", ex_a, 0);
      chk("rst_cnt", 32'(stall_cnt), 0);
      clrn = 0;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         clear_in();
         id_valid = tbl[i].id_valid; id_inst = tbl[i].inst; id_ctrl = tbl[i].ctrl;
         id_pc4 = 32'h1000 + 32'(i * 4); qa = tbl[i].qa; qb = tbl[i].qb;
         exs_valid = tbl[i].ev; exs_wreg = tbl[i].ew; exs_m2reg = tbl[i].em; exs_wn = tbl[i].ewn; exs_alu = tbl[i].ealu;
         mem_valid = tbl[i].mv; mem_wreg = tbl[i].mw; mem_m2reg = tbl[i].mm; mem_wn = tbl[i].mwn;
         mem_alu = tbl[i].malu; mem_mdata = tbl[i].mdat;
         wb_we = tbl[i].wwe; wb_wn = tbl[i].wwn; wb_d = tbl[i].wd;
         #1;
         exp_rn = tbl[i].inst[25:21];
         chk("tbl_rna", 32'(rna), 32'(exp_rn));
         exp_rn = tbl[i].inst[20:16];
         chk("tbl_rnb", 32'(rnb), 32'(exp_rn));
         chk("tbl_stall", 32'(stall), 32'(tbl[i].x_stall));
         @(posedge clk);
         #1;
         chk("tbl_valid", 32'(ex_valid), 32'(tbl[i].x_valid));
         chk("tbl_ctrl", 32'(ex_ctrl), tbl[i].id_valid ? 32'(tbl[i].ctrl) : 32'd0);
         chk("tbl_a", ex_a, tbl[i].x_a);
         chk("tbl_b", ex_b, tbl[i].x_b);
         chk("tbl_imm", ex_imm, tbl[i].x_imm);
         chk("tbl_wn", 32'(ex_wn), 32'(tbl[i].x_wn));
         chk("tbl_pc4", ex_pc4, 32'h1000 + 32'(i * 4));
      end

      @(negedge clk);
      set_load_use();
      #1 chk("lu_stall", 32'(stall), 1);
      @(posedge clk);
      #1;
      chk("lu_bubble_valid", 32'(ex_valid), 0);
      chk("lu_bubble_ctrl", 32'(ex_ctrl), 0);
      chk("lu_cnt", 32'(stall_cnt), 1);
      @(negedge clk);
      exs_valid = 0;
      mem_valid = 1; mem_wreg = 1; mem_m2reg = 1; mem_wn = 5'd4; mem_mdata = 32'h55; mem_alu = 32'h66;
      #1 chk("lu_retry_stall", 32'(stall), 0);
      @(posedge clk);
      #1;
      chk("lu_retry_a", ex_a, 32'h55);
      chk("lu_retry_b", ex_b, 3);
      chk("lu_retry_valid", 32'(ex_valid), 1);
      chk("lu_retry_wn", 32'(ex_wn), 5);
      chk("lu_retry_cnt", 32'(stall_cnt), 1);

      @(negedge clk);
      set_load_use();
      flush = 1;
      #1 chk("fl_stall", 32'(stall), 1);
      @(posedge clk);
      #1;
      chk("fl_valid", 32'(ex_valid), 0);
      chk("fl_cnt", 32'(stall_cnt), 1);

      @(negedge clk);
      clear_in();
      id_valid = 1; id_inst = 32'h00221820; id_ctrl = 8'h01; qa = 5; qb = 7;
      @(posedge clk);
      #1 chk("pre_rst_valid", 32'(ex_valid), 1);
      @(negedge clk);
      #1 clrn = 1;
      #1;
      chk("async_rst_valid", 32'(ex_valid), 0);
      chk("async_rst_a", ex_a, 0);
      chk("async_rst_cnt", 32'(stall_cnt), 0);
      #1 clrn = 0;
      m_cnt = 0;

      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         id_valid = $urandom_range(0, 3) != 0;
         id_inst = $urandom;
         id_inst[25:21] = 5'($urandom_range(0, 3));
         id_inst[20:16] = 5'($urandom_range(0, 3));
         id_pc4 = $urandom; id_ctrl = 8'($urandom);
         id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
         flush = $urandom_range(0, 9) == 0;
         qa = $urandom; qb = $urandom;
         exs_valid = 1'($urandom); exs_wreg = 1'($urandom); exs_m2reg = 1'($urandom);
         exs_wn = 5'($urandom_range(0, 3)); exs_alu = $urandom;
         mem_valid = 1'($urandom); mem_wreg = 1'($urandom); mem_m2reg = 1'($urandom);
         mem_wn = 5'($urandom_range(0, 3)); mem_alu = $urandom; mem_mdata = $urandom;
         wb_we = 1'($urandom); wb_wn = 5'($urandom_range(0, 3)); wb_d = $urandom;
         model_step();
      end

      @(negedge clk);
      clrn = 1;
      #1 clrn = 0;
      set_load_use();
      repeat (65534) @(posedge clk);
      #1 chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
      @(posedge clk);
      #1 chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
      repeat (3) @(posedge clk);
      #1 chk("sat_hold", 32'(stall_cnt), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-side operand stage of the 5-stage MIPS pipeline; sits directly downstream of the 32x32 register file.
- Drives the register-file read addresses and resolves RAW hazards by forwarding from EX/MEM/WB.
- Detects load-use hazards and stalls; registers the ID/EX pipeline latch consumed by the EX stage.

Parameters:
- CTRL_W, 8, width of the decoded control bundle carried into EX.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_inst  in  32  instruction word from IF/ID.
- id_pc4  in  32  PC+4 of the instruction.
- id_ctrl  in  CTRL_W  decoded control from the combinational control unit.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- flush  in  1  taken branch/jump resolved in EX; squash the ID instruction.
- rna  out  5  register-file read address A = inst[25:21].
- rnb  out  5  register-file read address B = inst[20:16].
- qa  in  32  register-file read data A.
- qb  in  32  register-file read data B.
- exs_valid, exs_wreg, exs_m2reg  in  1 each  instruction currently in EX.
- exs_wn  in  5  and  exs_alu  in  32  EX destination and ALU result.
- mem_valid, mem_wreg, mem_m2reg  in  1 each  and  mem_wn  in  5  MEM stage.
- mem_alu  in  32  and  mem_mdata  in  32  MEM ALU result and load data.
- wb_we  in  1,  wb_wn  in  5,  wb_d  in  32  write port currently presented to the register file.
- stall  out  1  combinational; IF/ID and PC hold when high.
- ex_valid  out  1,  ex_ctrl  out  CTRL_W,  ex_a  out  32,  ex_b  out  32  ID/EX latch.
- ex_imm  out  32,  ex_wn  out  5,  ex_pc4  out  32  ID/EX latch.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset: all ID/EX outputs, including ex_valid, clear to 0; stall_cnt clears to 0. Reset takes effect immediately and overrides the clock.
- rna and rnb are driven combinationally from id_inst, regardless of id_valid.
- Forward A operand (B is identical with rt/qb), first match wins:
  1. EX: exs_valid & exs_wreg & !exs_m2reg & exs_wn==rs -> exs_alu.
  2. MEM: mem_valid & mem_wreg & mem_wn==rs -> mem_mdata if mem_m2reg, else mem_alu.
  3. WB: wb_we & wb_wn==rs -> wb_d. The register file writes at the clock edge, so it returns the old value within the same cycle.
  4. Otherwise qa.
  - Register 0 never forwards; the operand is always 0.
- Load-use stall = id_valid & exs_valid & exs_wreg & exs_m2reg & exs_wn!=0 & ((id_use_rs & exs_wn==rs) | (id_use_rt & exs_wn==rt)).
- Clock-edge update, in priority order:
  1. flush: load a bubble (ex_valid=0, ex_ctrl=0; other fields don't-care but zeroed). Flush overrides stall.
  2. stall: load a bubble. The ID instruction is retried next cycle; the stall lasts exactly 1 cycle per load.
  3. Otherwise: ex_valid=id_valid; ex_ctrl=id_ctrl (zeroed if !id_valid); ex_a/ex_b = forwarded operands; ex_imm = sign-extended inst[15:0]; ex_pc4 = id_pc4.
- ex_wn selection: 31 if CTRL_JAL; else rt if CTRL_REGRT; else rd. Forced to 0 if CTRL_WREG is clear.
- Latency: 1 cycle from ID inputs to ID/EX outputs.
- stall_cnt increments on each edge where stall & !flush. It saturates at all-ones and does not wrap.

Decomposition:
- Package pipe_pkg holds:
  - CTRL_W.
  - Control bit indices: CTRL_WREG, CTRL_M2REG, CTRL_WMEM, CTRL_REGRT, CTRL_JAL, CTRL_ALUIMM, CTRL_SHIFT, CTRL_SEXT.
  - Field-slice constants RS_HI/LO, RT_HI/LO, RD_HI/LO.
- One natural sub-module, fwd_mux: purely combinational, instanced twice (A and B). Inputs: reg number, regfile data, EX/MEM/WB bypass sources. Output: selected operand.

Test Plan:
- No hazard: r1=5, r2=7 in regfile, add r3,r1,r2 -> next edge ex_a=5, ex_b=7, ex_wn=3, ex_valid=1, stall=0.
- EX forward: exs_wn=1, exs_alu=0x10, mem_wn=1, mem_alu=0x20, qa=5 -> ex_a=0x10 (EX priority over MEM and regfile).
- WB same-cycle: wb_we=1, wb_wn=2, wb_d=0xABCD, qb=0 -> ex_b=0xABCD. With wb_wn=0, qb is used and ex_b=0.
- Load-use: EX holds lw r4 (exs_m2reg=1), ID holds add r5,r4,r1:
  - stall=1 for 1 cycle, ex_valid=0, stall_cnt=1.
  - Next cycle MEM forwards mem_mdata=0x55 -> ex_a=0x55.
- Flush during stall: stall and flush both high -> bubble, stall_cnt unchanged.
- Reset mid-operation: clrn pulse between edges -> ex_valid=0, ex_a=0, stall_cnt=0 immediately.
- Saturation: force 2^16 stalls -> stall_cnt holds 0xFFFF.
